// File: rtl/hpdcache_demux_skid_pkg.sv
// Shared definitions for the hpdcache select-based mux/demux blocks.
// Both sides size their select bus through hpdcache_sel_width so they agree.
package hpdcache_demux_skid_pkg;

  // Select bus width: one bit per target when one-hot, otherwise a binary
  // index that is never narrower than one bit.
  function automatic int hpdcache_sel_width(input int noutput, input bit one_hot);
    if (one_hot) begin
      return noutput;
    end else if (noutput > 1) begin
      return $clog2(noutput);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/hpdcache_sel_decode.sv
// Combinational select decoder: binary or one-hot select to a one-hot
// destination, plus a flag telling whether the select names a real target.
// With a single target the select is ignored and always valid.
module hpdcache_sel_decode
  import hpdcache_demux_skid_pkg::*;
#(
  parameter int NOUTPUT     = 2,
  parameter bit ONE_HOT_SEL = 1'b0,
  parameter int SEL_WIDTH   = hpdcache_sel_width(NOUTPUT, ONE_HOT_SEL)
) (
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [NOUTPUT-1:0]   dest,
  output logic                 valid,
  output logic                 multi
);

  generate
    if (NOUTPUT == 1) begin : g_single
      logic unused_sel;
      assign unused_sel = ^sel;
      assign dest       = 1'b1;
      assign valid      = 1'b1;
      assign multi      = 1'b0;
    end else if (ONE_HOT_SEL) begin : g_onehot
      // Scan from the top down so that the lowest set bit is the last writer.
      always_comb begin
        dest = '0;
        for (int i = NOUTPUT - 1; i >= 0; i--) begin
          if (sel[i]) dest = NOUTPUT'(1) << i;
        end
      end
      assign valid = |sel;
      assign multi = |(sel & (sel - SEL_WIDTH'(1)));
    end else begin : g_binary
      // Indices at or above NOUTPUT leave dest empty and therefore invalid.
      always_comb begin
        dest = '0;
        for (int i = 0; i < NOUTPUT; i++) begin
          if (sel == SEL_WIDTH'(i)) dest[i] = 1'b1;
        end
      end
      assign valid = |dest;
      assign multi = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/hpdcache_demux_skid.sv
// Registered 1:N demultiplexer with a 2-entry skid buffer. The head entry
// drives the outputs, the skid entry absorbs the one transfer accepted while
// the head is stalled, and in_ready_o comes straight from a flop.
module hpdcache_demux_skid
  import hpdcache_demux_skid_pkg::*;
#(
  parameter int  NOUTPUT     = 2,
  parameter int  DATA_WIDTH  = 1,
  parameter bit  ONE_HOT_SEL = 1'b0,
  localparam int SEL_WIDTH   = hpdcache_sel_width(NOUTPUT, ONE_HOT_SEL)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [SEL_WIDTH-1:0]  in_sel_i,
  output logic [NOUTPUT-1:0]    out_valid_o,
  input  logic [NOUTPUT-1:0]    out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  err_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  in_ready_q;
  logic                  err_q;
  logic [NOUTPUT-1:0]    main_dest_q, skid_dest_q;
  logic [DATA_WIDTH-1:0] main_data_q, skid_data_q;

  logic [NOUTPUT-1:0]    sel_dest;
  logic                  sel_ok;
  logic                  sel_multi;
  logic                  acc, acc_ok, deq;
  logic                  load_main_in, load_skid, move_skid;

  hpdcache_sel_decode #(
    .NOUTPUT    (NOUTPUT),
    .ONE_HOT_SEL(ONE_HOT_SEL),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_sel_decode (
    .sel  (in_sel_i),
    .dest (sel_dest),
    .valid(sel_ok),
    .multi(sel_multi)
  );

  // Invalid selects are still accepted (handshake completes) but never stored.
  assign acc    = in_valid_i & in_ready_q;
  assign acc_ok = acc & sel_ok;
  assign deq    = (state_q != ST_EMPTY) & (|(main_dest_q & out_ready_i));

  // Next-state and storage load decisions for the two-entry buffer.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc_ok) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc_ok && deq) begin
          load_main_in = 1'b1;
        end else if (acc_ok) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (deq) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deq) begin
          state_d   = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Control state: occupancy, registered ready and the error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      err_q      <= acc & ~sel_ok;
    end
  end

  // Payload and destination storage; gated by state so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (load_main_in) begin
      main_data_q <= in_data_i;
      main_dest_q <= sel_dest;
    end else if (move_skid) begin
      main_data_q <= skid_data_q;
      main_dest_q <= skid_dest_q;
    end
    if (load_skid) begin
      skid_data_q <= in_data_i;
      skid_dest_q <= sel_dest;
    end
  end

  // Flag one-hot selects with several bits set; the lowest bit is used.
  always @(posedge clk_i) begin
    if (!rst_i && acc) begin
      assert (!sel_multi)
        else $warning("hpdcache_demux_skid: one-hot select with several bits set, lowest bit used");
    end
  end

  assign in_ready_o  = in_ready_q;
  assign err_o       = err_q;
  assign out_valid_o = (state_q != ST_EMPTY) ? main_dest_q : '0;
  assign out_data_o  = main_data_q;

endmodule

// File: tb/tb_hpdcache_demux_skid.sv
// Directed bench for hpdcache_demux_skid: four instances cover binary and
// one-hot selects, invalid selects and the single-output degenerate case.
module tb_hpdcache_demux_skid;

  logic clk;
  logic rst;

  int checks;
  int failures;

  // Instance A: 4 outputs, binary select
  logic       a_in_valid, a_in_ready, a_err;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_in_sel;
  logic [3:0] a_out_valid, a_out_ready;

  // Instance B: 3 outputs, binary select
  logic       b_in_valid, b_in_ready, b_err;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_in_sel;
  logic [2:0] b_out_valid, b_out_ready;

  // Instance C: 4 outputs, one-hot select
  logic       c_in_valid, c_in_ready, c_err;
  logic [7:0] c_in_data, c_out_data;
  logic [3:0] c_in_sel;
  logic [3:0] c_out_valid, c_out_ready;

  // Instance D: single output
  logic       d_in_valid, d_in_ready, d_err;
  logic [7:0] d_in_data, d_out_data;
  logic [0:0] d_in_sel;
  logic [0:0] d_out_valid, d_out_ready;

  hpdcache_demux_skid #(.NOUTPUT(4), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b0)) u_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data), .in_sel_i(a_in_sel),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data), .err_o(a_err)
  );

  hpdcache_demux_skid #(.NOUTPUT(3), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data), .in_sel_i(b_in_sel),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data), .err_o(b_err)
  );

  hpdcache_demux_skid #(.NOUTPUT(4), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data), .in_sel_i(c_in_sel),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data), .err_o(c_err)
  );

  hpdcache_demux_skid #(.NOUTPUT(1), .DATA_WIDTH(8), .ONE_HOT_SEL(1'b0)) u_d (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(d_in_valid), .in_ready_o(d_in_ready), .in_data_i(d_in_data), .in_sel_i(d_in_sel),
    .out_valid_o(d_out_valid), .out_ready_i(d_out_ready), .out_data_o(d_out_data), .err_o(d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev_data;
    logic [1:0] prev_sel;
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int         d_cnt;

    checks   = 0;
    failures = 0;
    d_cnt    = 0;
    prev_data = '0;
    prev_sel  = '0;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = 4'b1111;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = 3'b111;
    c_in_valid = 1'b0; c_in_data = '0; c_in_sel = '0; c_out_ready = 4'b1111;
    d_in_valid = 1'b0; d_in_data = '0; d_in_sel = '0; d_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_a_ready", 32'(a_in_ready), 0);
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_err", 32'(a_err), 0);
    chk("rst_d_ready", 32'(d_in_ready), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_a_ready", 32'(a_in_ready), 1);
    chk("post_rst_b_ready", 32'(b_in_ready), 1);
    chk("post_rst_c_ready", 32'(c_in_ready), 1);
    chk("post_rst_d_ready", 32'(d_in_ready), 1);

    // Single transfer: 0xA5 to output 2, visible one cycle later
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_in_sel = 2'd2;
    chk("t1_before_valid", 32'(a_out_valid), 0);
    tick();
    a_in_valid = 1'b0;
    chk("t1_valid", 32'(a_out_valid), 4);
    chk("t1_data", 32'(a_out_data), 32'hA5);
    tick();
    chk("t1_drained", 32'(a_out_valid), 0);

    // Sixteen back-to-back transfers with random selects
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk("bb_valid", 32'(a_out_valid), 32'(4'b0001 << prev_sel));
        chk("bb_data", 32'(a_out_data), 32'(prev_data));
        chk("bb_ready", 32'(a_in_ready), 1);
      end
      if (i < 16) begin
        a_in_valid = 1'b1;
        a_in_data  = 8'(i * 17 + 3);
        a_in_sel   = 2'($urandom_range(0, 3));
        prev_data  = a_in_data;
        prev_sel   = a_in_sel;
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
    end
    chk("bb_drained", 32'(a_out_valid), 0);

    // Backpressure on output 1: three transfers, third is held
    a_out_ready = 4'b1101;
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h11;
    tick();
    chk("bp_c1_ready", 32'(a_in_ready), 1);
    chk("bp_c1_valid", 32'(a_out_valid), 2);
    a_in_data = 8'h22;
    tick();
    chk("bp_c2_ready_low", 32'(a_in_ready), 0);
    chk("bp_c2_data", 32'(a_out_data), 32'h11);
    a_in_data = 8'h33;
    tick();
    chk("bp_c3_ready_low", 32'(a_in_ready), 0);
    chk("bp_c3_valid", 32'(a_out_valid), 2);
    chk("bp_c3_data_stable", 32'(a_out_data), 32'h11);
    a_out_ready = 4'b1111;
    tick();
    chk("bp_c4_ready", 32'(a_in_ready), 1);
    chk("bp_c4_valid", 32'(a_out_valid), 2);
    chk("bp_c4_data", 32'(a_out_data), 32'h22);
    tick();
    a_in_valid = 1'b0;
    chk("bp_c5_valid", 32'(a_out_valid), 2);
    chk("bp_c5_data", 32'(a_out_data), 32'h33);
    tick();
    chk("bp_c6_drained", 32'(a_out_valid), 0);

    // Head-of-line: head to stalled output 0, skid entry to output 3
    a_out_ready = 4'b1110;
    a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_data = 8'h40;
    tick();
    a_in_sel = 2'd3; a_in_data = 8'h43;
    chk("hol_c1_valid", 32'(a_out_valid), 1);
    tick();
    a_in_valid = 1'b0;
    chk("hol_c2_valid", 32'(a_out_valid), 1);
    chk("hol_c2_ready", 32'(a_in_ready), 0);
    tick();
    chk("hol_c3_valid", 32'(a_out_valid), 1);
    chk("hol_c3_data", 32'(a_out_data), 32'h40);
    a_out_ready = 4'b1111;
    tick();
    chk("hol_c4_valid", 32'(a_out_valid), 8);
    chk("hol_c4_data", 32'(a_out_data), 32'h43);
    tick();
    chk("hol_c5_drained", 32'(a_out_valid), 0);

    // Reset while FULL discards both entries
    a_out_ready = 4'b0000;
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'h51;
    tick();
    a_in_data = 8'h52;
    tick();
    a_in_valid = 1'b0;
    chk("rmid_full_ready", 32'(a_in_ready), 0);
    chk("rmid_full_valid", 32'(a_out_valid), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_out_ready = 4'b1111;
    chk("rmid_valid", 32'(a_out_valid), 0);
    chk("rmid_ready", 32'(a_in_ready), 0);
    chk("rmid_err", 32'(a_err), 0);
    tick();
    chk("rmid_ready_back", 32'(a_in_ready), 1);
    chk("rmid_no_valid1", 32'(a_out_valid), 0);
    tick();
    chk("rmid_no_valid2", 32'(a_out_valid), 0);

    // Invalid binary select on a 3-output instance
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h77;
    tick();
    chk("inv_b_err", 32'(b_err), 1);
    chk("inv_b_valid", 32'(b_out_valid), 0);
    chk("inv_b_ready", 32'(b_in_ready), 1);
    b_in_sel = 2'd2; b_in_data = 8'h78;
    tick();
    b_in_valid = 1'b0;
    chk("inv_b_err_pulse", 32'(b_err), 0);
    chk("inv_b_next_valid", 32'(b_out_valid), 4);
    chk("inv_b_next_data", 32'(b_out_data), 32'h78);
    tick();
    chk("inv_b_drained", 32'(b_out_valid), 0);

    // One-hot: zero select, multi-bit select, single-bit select
    c_in_valid = 1'b1; c_in_sel = 4'b0000; c_in_data = 8'h60;
    tick();
    chk("oh_zero_err", 32'(c_err), 1);
    chk("oh_zero_valid", 32'(c_out_valid), 0);
    c_in_sel = 4'b0110; c_in_data = 8'h61;
    tick();
    chk("oh_multi_err", 32'(c_err), 0);
    chk("oh_multi_valid", 32'(c_out_valid), 2);
    chk("oh_multi_data", 32'(c_out_data), 32'h61);
    c_in_sel = 4'b1000; c_in_data = 8'h62;
    tick();
    c_in_valid = 1'b0;
    chk("oh_single_valid", 32'(c_out_valid), 8);
    chk("oh_single_data", 32'(c_out_data), 32'h62);
    tick();
    chk("oh_drained", 32'(c_out_valid), 0);

    // Single output: random valid/ready against a FIFO scoreboard
    for (int cyc = 0; cyc < 1000; cyc++) begin
      d_in_valid  = 1'($urandom_range(0, 1));
      d_in_data   = 8'($urandom_range(0, 255));
      d_in_sel    = 1'($urandom_range(0, 1));
      d_out_ready = 1'($urandom_range(0, 1));
      chk("d_err", 32'(d_err), 0);
      if (d_out_valid[0] && d_out_ready[0]) begin
        chk("d_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          chk("d_data", 32'(d_out_data), 32'(exp_d));
          d_cnt++;
        end
      end
      if (d_in_valid && d_in_ready) q.push_back(d_in_data);
      tick();
    end
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (d_out_valid[0]) begin
        chk("d_drain_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          chk("d_drain_data", 32'(d_out_data), 32'(exp_d));
          d_cnt++;
        end
      end
      tick();
    end
    chk("d_all_delivered", 32'(q.size()), 0);
    chk("d_final_valid", 32'(d_out_valid), 0);
    chk("d_some_traffic", 32'(d_cnt > 50), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
